// File: rtl/led_serial_enc.sv
// Serial LED encoder: pulls words from an async FIFO read port and drives a
// single-wire SK6812/WS2812 style bitstream, MSB first. Supports in-band
// stream-reset commands, automatic frame termination and a one-word prefetch
// buffer so consecutive words are sent without a gap.
module led_serial_enc #(
    parameter int unsigned BITS_PER_WORD   = 32,
    parameter int unsigned T0H             = 16,
    parameter int unsigned T0L             = 74,
    parameter int unsigned T1H             = 45,
    parameter int unsigned T1L             = 45,
    parameter int unsigned RST_CLKS        = 7681,
    parameter int unsigned WORDS_PER_FRAME = 0,
    parameter int unsigned COUNTER_MAX     = 7800
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_rd_fifo_empty,
    input  logic [BITS_PER_WORD:0] in_rd_fifo_data,
    output logic                   out_rd_fifo_en,
    output logic                   out_sig,
    output logic                   out_busy,
    output logic                   out_underrun,
    output logic [15:0]            out_word_count
);

    localparam int unsigned CW = $clog2(COUNTER_MAX + 1);
    localparam int unsigned BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

    localparam logic [CW-1:0] T0H_END  = CW'(T0H - 1);
    localparam logic [CW-1:0] T0L_END  = CW'(T0L - 1);
    localparam logic [CW-1:0] T1H_END  = CW'(T1H - 1);
    localparam logic [CW-1:0] T1L_END  = CW'(T1L - 1);
    localparam logic [CW-1:0] RST_END  = CW'(RST_CLKS - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(BITS_PER_WORD - 1);
    localparam logic [15:0]   WPF      = 16'(WORDS_PER_FRAME);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StHigh,
        StLow,
        StRstLow
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic [BW-1:0]            bit_q, bit_d;
    logic [BITS_PER_WORD:0]   buf_q, buf_d;
    logic                     buf_valid_q, buf_valid_d;
    logic                     pf_req_q, pf_req_d;
    logic                     pf_cap_q, pf_cap_d;
    logic                     rd_en_q, rd_en_d;
    logic                     sig_q;
    logic                     busy_q;
    logic                     underrun_q, underrun_d;
    logic [15:0]              word_count_q, word_count_d;

    logic                     take_buf;
    logic [15:0]              wc_inc;
    logic                     cur_bit;
    logic [CW-1:0]            high_end;
    logic [CW-1:0]            low_end;
    logic                     underrun_armed;

    assign cur_bit  = shift_q[BITS_PER_WORD-1];
    assign high_end = cur_bit ? T1H_END : T0H_END;
    assign low_end  = cur_bit ? T1L_END : T0L_END;
    // A partial frame is only meaningful when frames have a fixed length.
    assign underrun_armed = (WORDS_PER_FRAME != 0) && (word_count_q != 16'd0) &&
                            (word_count_q < WPF);

    // Next-state, datapath and prefetch control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        pf_req_d     = 1'b0;
        pf_cap_d     = pf_req_q;
        rd_en_d      = 1'b0;
        underrun_d   = 1'b0;
        word_count_d = word_count_q;
        take_buf     = 1'b0;
        wc_inc       = (word_count_q == 16'hFFFF) ? word_count_q : word_count_q + 16'd1;

        // Prefetched data is valid the clock after its read pulse.
        if (pf_cap_q) begin
            buf_d       = in_rd_fifo_data;
            buf_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (buf_valid_q) begin
                    take_buf = 1'b1;
                end else if (!pf_req_q && !pf_cap_q && !in_rd_fifo_empty) begin
                    state_d = StFetch;
                    rd_en_d = 1'b1;
                end else if (underrun_armed) begin
                    if (cnt_q == RST_END) begin
                        underrun_d   = 1'b1;
                        word_count_d = 16'd0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StFetch: begin
                state_d = StWait;
            end
            StWait: begin
                cnt_d = '0;
                if (in_rd_fifo_data[BITS_PER_WORD]) begin
                    state_d = StRstLow;
                end else begin
                    shift_d = in_rd_fifo_data[BITS_PER_WORD-1:0];
                    bit_d   = LAST_IDX;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (cnt_q == high_end) begin
                    cnt_d   = '0;
                    state_d = StLow;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StLow: begin
                if (cnt_q == low_end) begin
                    cnt_d = '0;
                    if (bit_q != '0) begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q - BW'(1);
                        state_d = StHigh;
                    end else begin
                        word_count_d = wc_inc;
                        if ((WORDS_PER_FRAME != 0) && (wc_inc == WPF)) begin
                            state_d = StRstLow;
                        end else if (buf_valid_q) begin
                            take_buf = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StRstLow: begin
                if (cnt_q == RST_END) begin
                    cnt_d        = '0;
                    word_count_d = 16'd0;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Consume the prefetch buffer: a command goes straight to the reset low.
        if (take_buf) begin
            buf_valid_d = 1'b0;
            cnt_d       = '0;
            if (buf_q[BITS_PER_WORD]) begin
                state_d = StRstLow;
            end else begin
                shift_d = buf_q[BITS_PER_WORD-1:0];
                bit_d   = LAST_IDX;
                state_d = StHigh;
            end
        end

        // One outstanding prefetch at most; the buffer is never overwritten.
        if ((state_q == StHigh || state_q == StLow) && !buf_valid_q && !pf_req_q &&
            !pf_cap_q && !in_rd_fifo_empty) begin
            rd_en_d  = 1'b1;
            pf_req_d = 1'b1;
        end
    end

    // State and output registers; reset drops the line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_q        <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            pf_req_q     <= 1'b0;
            pf_cap_q     <= 1'b0;
            rd_en_q      <= 1'b0;
            sig_q        <= 1'b0;
            busy_q       <= 1'b0;
            underrun_q   <= 1'b0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            pf_req_q     <= pf_req_d;
            pf_cap_q     <= pf_cap_d;
            rd_en_q      <= rd_en_d;
            sig_q        <= (state_d == StHigh);
            busy_q       <= (state_d != StIdle);
            underrun_q   <= underrun_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_rd_fifo_en = rd_en_q;
    assign out_sig        = sig_q;
    assign out_busy       = busy_q;
    assign out_underrun   = underrun_q;
    assign out_word_count = word_count_q;

endmodule

// File: tb/tb_led_serial_enc.sv
// Bench for led_serial_enc: two instances (free-running and 2-word frames),
// each fed by a small FIFO model and watched by a pulse monitor.
module tb_led_serial_enc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en      [2];
    logic        sig        [2];
    logic        busy       [2];
    logic        under      [2];
    logic [15:0] wcnt       [2];
    logic [24:0] fdata      [2];
    logic        fifo_empty [2];
    logic [24:0] mem        [2][16];
    int          wp         [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    led_serial_enc #(
        .BITS_PER_WORD(24), .T0H(2), .T0L(6), .T1H(4), .T1L(4), .RST_CLKS(20),
        .WORDS_PER_FRAME(0), .COUNTER_MAX(63)
    ) dut0 (
        .clk(clk), .rst(rst), .in_rd_fifo_empty(fifo_empty[0]), .in_rd_fifo_data(fdata[0]),
        .out_rd_fifo_en(rd_en[0]), .out_sig(sig[0]), .out_busy(busy[0]),
        .out_underrun(under[0]), .out_word_count(wcnt[0])
    );

    led_serial_enc #(
        .BITS_PER_WORD(24), .T0H(2), .T0L(6), .T1H(4), .T1L(4), .RST_CLKS(20),
        .WORDS_PER_FRAME(2), .COUNTER_MAX(63)
    ) dut1 (
        .clk(clk), .rst(rst), .in_rd_fifo_empty(fifo_empty[1]), .in_rd_fifo_data(fdata[1]),
        .out_rd_fifo_en(rd_en[1]), .out_sig(sig[1]), .out_busy(busy[1]),
        .out_underrun(under[1]), .out_word_count(wcnt[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_ch
        int          rp = 0;
        int          pulses, wide, hi, last_rise, reads, unders, under_at, maxlow, badw;
        int          hi_run, lo_run, t, t0, idle_run, viol;
        bit          first, seen, prev;
        logic [63:0] cap;

        assign fifo_empty[g] = (wp[g] == rp);

        // FIFO read port with registered data.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                rp       <= 0;
                fdata[g] <= '0;
            end else if (rd_en[g] && !fifo_empty[g]) begin
                fdata[g] <= mem[g][rp % 16];
                rp       <= rp + 1;
            end
        end

        // Pulse monitor, sampled on the inactive edge.
        always @(negedge clk) begin
            if (rd_en[g] && fifo_empty[g]) viol++;
            if (rst) begin
                pulses = 0; wide = 0; hi = 0; last_rise = 0; reads = 0; unders = 0;
                under_at = 0; maxlow = 0; badw = 0; hi_run = 0; lo_run = 0; t = 0;
                t0 = 0; idle_run = 0; first = 0; seen = 0; prev = 0; cap = '0;
            end else begin
                t++;
                if (busy[g]) seen = 1;
                if (rd_en[g]) reads++;
                if (busy[g]) idle_run = 0;
                else idle_run++;
                if (under[g]) begin
                    unders++;
                    under_at = idle_run;
                end
                if (sig[g]) begin
                    if (!prev) begin
                        if (!first) begin
                            first = 1;
                            t0    = t;
                        end else if (lo_run > maxlow) begin
                            maxlow = lo_run;
                        end
                        last_rise = t - t0;
                        lo_run    = 0;
                    end
                    hi_run++;
                    hi++;
                end else begin
                    if (prev) begin
                        pulses++;
                        cap = {cap[62:0], hi_run == 4};
                        if (hi_run == 4) wide++;
                        else if (hi_run != 2) badw++;
                        hi_run = 0;
                    end
                    lo_run++;
                end
                prev = sig[g];
            end
        end
    end

    typedef struct {
        int          nw;
        logic [24:0] w0;
        logic [24:0] w1;
        int          pulses;
        int          wide;
        int          hi;
        int          last_rise;
        int          reads;
        int          count;
        logic [63:0] cap;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic push(input int inst, input logic [24:0] v);
        mem[inst][wp[inst] % 16] = v;
        wp[inst]++;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        wp[0] = 0;
        wp[1] = 0;
        rst   = 1'b0;
    endtask

    task automatic wait_idle(input int inst, input int budget);
        int n    = 0;
        int idle = 0;
        bit s;
        while (idle < 3 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            s = (inst == 0) ? g_ch[0].seen : g_ch[1].seen;
            if (!busy[inst] && fifo_empty[inst] && s) idle++;
            else idle = 0;
        end
        if (idle < 3) begin
            n_chk++;
            $display("FAIL wait_idle inst%0d: still busy after %0d cycles, want idle", inst, n);
        end
    endtask

    initial begin
        // 24-bit words, every bit 8 clocks: a word's last rise is 23*8 = 184.
        vecs[0] = '{1, 25'h0A00001, 25'h0, 24, 3, 54, 184, 1, 1, 64'hA00001};
        vecs[1] = '{2, 25'h0FFFFFF, 25'h0000000, 48, 24, 144, 376, 2, 2, 64'hFFFFFF000000};
        vecs[2] = '{1, 25'h1000000, 25'h0, 0, 0, 0, 0, 1, 0, 64'h0};
        vecs[3] = '{2, 25'h0800000, 25'h1000000, 24, 1, 50, 184, 2, 0, 64'h800000};
        vecs[4] = '{1, 25'h0123456, 25'h0, 24, 9, 66, 184, 1, 1, 64'h123456};
        wp[0] = 0;
        wp[1] = 0;

        // Reset held with data waiting in both FIFOs.
        push(0, 25'h0A00001);
        push(1, 25'h0A00001);
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst sig%0d", i), sig[i], 0);
            chk($sformatf("rst rd_en%0d", i), rd_en[i], 0);
            chk($sformatf("rst busy%0d", i), busy[i], 0);
            chk($sformatf("rst underrun%0d", i), under[i], 0);
            chk($sformatf("rst count%0d", i), wcnt[i], 0);
        end

        // Directed vectors on the free-running instance.
        for (int i = 0; i < 5; i++) begin
            do_reset(2);
            push(0, vecs[i].w0);
            if (vecs[i].nw > 1) push(0, vecs[i].w1);
            wait_idle(0, 2000);
            chk($sformatf("v%0d pulses", i), g_ch[0].pulses, vecs[i].pulses);
            chk($sformatf("v%0d wide", i), g_ch[0].wide, vecs[i].wide);
            chk($sformatf("v%0d high_clks", i), g_ch[0].hi, vecs[i].hi);
            chk($sformatf("v%0d last_rise", i), g_ch[0].last_rise, vecs[i].last_rise);
            chk($sformatf("v%0d reads", i), g_ch[0].reads, vecs[i].reads);
            chk($sformatf("v%0d count", i), wcnt[0], vecs[i].count);
            chk($sformatf("v%0d bits", i), g_ch[0].cap, vecs[i].cap);
            chk($sformatf("v%0d bad_width", i), g_ch[0].badw, 0);
        end

        // Two-word frames, three words: word3 rise at 192+192+20+1+23*8 = 589;
        // longest low = last 1-bit low 4 + reset 20 + idle 1 = 25.
        do_reset(2);
        push(1, 25'h0000001);
        push(1, 25'h0000001);
        push(1, 25'h0800000);
        wait_idle(1, 3000);
        chk("frame pulses", g_ch[1].pulses, 72);
        chk("frame wide", g_ch[1].wide, 3);
        chk("frame high_clks", g_ch[1].hi, 150);
        chk("frame last_rise", g_ch[1].last_rise, 589);
        chk("frame max_low", g_ch[1].maxlow, 25);
        chk("frame reads", g_ch[1].reads, 3);
        chk("frame count", wcnt[1], 1);
        chk("frame bits", g_ch[1].cap, 64'h0001000001800000);

        // Underrun: one word of a two-word frame, then nothing.
        do_reset(2);
        push(1, 25'h0000001);
        wait_idle(1, 2000);
        chk("underrun count before", wcnt[1], 1);
        chk("underrun early", g_ch[1].unders, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("underrun pulses", g_ch[1].unders, 1);
        // Pulse visible in idle cycle 21, i.e. 20 clocks after entering idle.
        chk("underrun timing", g_ch[1].under_at, 21);
        chk("underrun count after", wcnt[1], 0);

        // Reset asserted mid-HIGH drops the line in the same cycle.
        do_reset(2);
        push(0, 25'h0FFFFFF);
        begin
            int n = 0;
            while (!sig[0] && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("mid-high reached", sig[0], 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid-high rst sig", sig[0], 0);
        chk("mid-high rst busy", busy[0], 0);
        @(posedge clk);
        #1;
        wp[0] = 0;
        wp[1] = 0;
        rst   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rd_en while empty 0", g_ch[0].viol, 0);
        chk("rd_en while empty 1", g_ch[1].viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
